ibex_data_bus_responder: RTL and testbench

Responder (memory) end of the core's data-bus req/gnt/rvalid protocol. It accepts core LSU requests, performs byte-enabled writes to, and word reads from, an internal word array. It returns responses in order after a fixed latency, and flags accesses outside the mapped window with an error. Used as the data-side memory in block- and core-level simulation, and as a small tightly-coupled data RAM on FPGA builds.

---
 rtl/ibex_pkg.sv | 37 +++
 rtl/ibex_data_bus_responder_chk.sv | 47 ++++
 rtl/ibex_resp_delay_line.sv | 36 +++
 rtl/ibex_data_bus_responder.sv | 130 +++++++++++++
 tb/tb_ibex_data_bus_responder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_pkg.sv
// Data-bus request/response types shared by the core-side LSU and the memory
// responders, plus the byte-lane merge used for partial stores.
package ibex_pkg;

   localparam int unsigned BusDataW = 32;
   localparam int unsigned BusBeW   = 4;

   typedef struct packed {
      logic                req;
      logic                we;
      logic [BusBeW-1:0]   be;
      logic [31:0]         addr;
      logic [BusDataW-1:0] wdata;
   } data_req_t;

   typedef struct packed {
      logic                rvalid;
      logic [BusDataW-1:0] rdata;
      logic                err;
   } data_rsp_t;

   function automatic logic [BusDataW-1:0] be_merge(input logic [BusDataW-1:0] old_w,
                                                    input logic [BusDataW-1:0] new_w,
                                                    input logic [BusBeW-1:0]   be);
      logic [BusDataW-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(BusBeW); i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ibex_data_bus_responder_chk.sv
// Simulation-only protocol and parameter checks for the data-bus responder.
module ibex_data_bus_responder_chk #(
   parameter logic [31:0] AddrBase       = 32'h0001_0000,
   parameter int unsigned MemWords       = 256,
   parameter int unsigned RespLatency    = 2,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned CntW           = 2
) (
   input logic            clk_i,
   input logic            rst_ni,
   input logic            data_req_i,
   input logic            data_gnt_o,
   input logic            data_we_i,
   input logic [3:0]      data_be_i,
   input logic [31:0]     data_addr_i,
   input logic [31:0]     data_wdata_i,
   input logic            data_rvalid_o,
   input logic [CntW-1:0] inflight_o
);

   if (MemWords < 4 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_words
      $error("MemWords must be a power of two and at least 4");
   end
   if (RespLatency < 1 || RespLatency > 8) begin : g_bad_lat
      $error("RespLatency must be in 1..8");
   end
   if (MaxOutstanding < 1 || MaxOutstanding > RespLatency) begin : g_bad_out
      $error("MaxOutstanding must be in 1..RespLatency");
   end
   if (AddrBase[1:0] != 2'b00) begin : g_bad_base
      $error("AddrBase must be word aligned");
   end

   a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (data_req_i && !data_gnt_o) |=>
      (data_req_i && $stable({data_we_i, data_be_i, data_addr_i, data_wdata_i})))
      else $error("request fields changed while waiting for grant");

   a_rvalid_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
      data_rvalid_o |-> (inflight_o != '0))
      else $error("rvalid with nothing outstanding");

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      inflight_o <= CntW'(MaxOutstanding))
      else $error("outstanding count above limit");

endmodule

// File: rtl/ibex_resp_delay_line.sv
// Fixed-depth valid/data shift pipeline; payload of empty slots is forced to
// zero so the tail can drive idle bus outputs directly.
module ibex_resp_delay_line #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 33
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   output logic [Width-1:0] data_o
);

   logic [Depth-1:0]            valid_q;
   logic [Depth-1:0][Width-1:0] data_q;

   // Shift every slot one stage toward the output each cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q[0] <= valid_i;
         data_q[0]  <= valid_i ? data_i : '0;
         for (int i = 1; i < int'(Depth); i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[Depth-1];
   assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/ibex_data_bus_responder.sv
// Memory-side end of the data bus: byte-enabled word array behind a
// req/gnt/rvalid handshake with fixed-latency, in-order responses.
module ibex_data_bus_responder
   import ibex_pkg::*;
#(
   parameter logic [31:0] AddrBase       = 32'h0001_0000,
   parameter int unsigned MemWords       = 256,
   parameter int unsigned RespLatency    = 2,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  data_req_i,
   output logic                                  data_gnt_o,
   input  logic                                  data_we_i,
   input  logic [3:0]                            data_be_i,
   input  logic [31:0]                           data_addr_i,
   input  logic [31:0]                           data_wdata_i,
   output logic                                  data_rvalid_o,
   output logic [31:0]                           data_rdata_o,
   output logic                                  data_err_o,
   input  logic                                  stall_i,
   output logic [$clog2(MaxOutstanding+1)-1:0]   inflight_o
);

   localparam int unsigned IdxW = $clog2(MemWords);
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   data_req_t        req_s;
   data_rsp_t        rsp_s;
   logic [31:0]      mem_q [MemWords];
   logic [31:0]      offset_s;
   logic             hit_s;
   logic [IdxW-1:0]  idx_s;
   logic             gnt_s;
   logic [31:0]      ins_rdata_s;
   logic             ins_err_s;
   logic [32:0]      pipe_data_s;
   logic             pipe_valid_s;
   logic [CntW-1:0]  inflight_q, inflight_d;
   logic             unused_s;

   assign req_s = '{req: data_req_i, we: data_we_i, be: data_be_i,
                    addr: data_addr_i, wdata: data_wdata_i};

   // Unsigned wrap makes addresses below the base land far above the window.
   assign offset_s = req_s.addr - AddrBase;
   assign hit_s    = offset_s < 32'(4 * MemWords);
   assign idx_s    = offset_s[IdxW+1:2];
   assign unused_s = ^{offset_s[1:0], offset_s[31:IdxW+2]};

   assign gnt_s = req_s.req & ~stall_i & (inflight_q < CntW'(MaxOutstanding));

   // Array write port; contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (gnt_s && req_s.we && hit_s) begin
         mem_q[idx_s] <= be_merge(mem_q[idx_s], req_s.wdata, req_s.be);
      end
   end

   // Response payload captured at grant: only hitting loads carry data.
   always_comb begin
      ins_err_s   = ~hit_s;
      ins_rdata_s = '0;
      if (hit_s && !req_s.we) begin
         ins_rdata_s = mem_q[idx_s];
      end else begin
         ins_rdata_s = '0;
      end
   end

   ibex_resp_delay_line #(
      .Depth (RespLatency),
      .Width (33)
   ) u_delay (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (gnt_s),
      .data_i  ({ins_err_s, ins_rdata_s}),
      .valid_o (pipe_valid_s),
      .data_o  (pipe_data_s)
   );

   assign rsp_s = '{rvalid: pipe_valid_s, rdata: pipe_data_s[31:0], err: pipe_data_s[32]};

   // Credit counter: a slot freed by rvalid is only reusable next cycle.
   always_comb begin
      inflight_d = inflight_q;
      case ({gnt_s, rsp_s.rvalid})
         2'b10:   inflight_d = inflight_q + CntW'(1);
         2'b01:   inflight_d = inflight_q - CntW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // Outstanding-request register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q <= '0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   assign data_gnt_o    = gnt_s;
   assign data_rvalid_o = rsp_s.rvalid;
   assign data_rdata_o  = rsp_s.rdata;
   assign data_err_o    = rsp_s.err;
   assign inflight_o    = inflight_q;

   ibex_data_bus_responder_chk #(
      .AddrBase       (AddrBase),
      .MemWords       (MemWords),
      .RespLatency    (RespLatency),
      .MaxOutstanding (MaxOutstanding),
      .CntW           (CntW)
   ) u_chk (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .data_req_i    (data_req_i),
      .data_gnt_o    (gnt_s),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_rvalid_o (rsp_s.rvalid),
      .inflight_o    (inflight_q)
   );

endmodule

// File: tb/tb_ibex_data_bus_responder.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized phase, all scored against a queue-based transaction model.
module tb_ibex_data_bus_responder;

   localparam logic [31:0] Base   = 32'h0001_0000;
   localparam int          Words  = 256;
   localparam int          Lat    = 2;
   localparam int          MaxOut = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        data_req_i = 1'b0, data_we_i = 1'b0, stall_i = 1'b0;
   logic [3:0]  data_be_i = 4'h0;
   logic [31:0] data_addr_i = 32'h0, data_wdata_i = 32'h0;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic [1:0]  inflight_o;

   always #5 clk_i = ~clk_i;

   ibex_data_bus_responder #(
      .AddrBase(Base), .MemWords(Words), .RespLatency(Lat), .MaxOutstanding(MaxOut)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
      .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .data_err_o(data_err_o), .stall_i(stall_i), .inflight_o(inflight_o)
   );

   typedef struct { int due; bit err; logic [31:0] rdata; logic [3:0] mask; } exp_t;
   typedef struct { bit we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
                    logic [31:0] exp_rdata; bit exp_err; } vec_t;

   exp_t        q[$];
   logic [31:0] mem [Words];
   logic [3:0]  kn  [Words];
   int          cyc = 0, checks = 0, errors = 0;
   bit          s_gnt = 1'b0, s_rv = 1'b0, s_err = 1'b0;
   logic [31:0] s_rdata = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [3:0] m);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
      return r;
   endfunction

   // One bus cycle: drive, check at negedge against the model, advance model.
   task automatic step(input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit stall);
      logic [31:0] off;
      bit          hit, eg, erv;
      int          idx;
      exp_t        e;
      data_req_i = req; data_we_i = we; data_be_i = be;
      data_addr_i = addr; data_wdata_i = wdata; stall_i = stall;
      @(negedge clk_i);
      off = addr - Base;
      hit = off < 32'(4 * Words);
      idx = hit ? int'(off >> 2) : 0;
      eg  = req && !stall && (q.size() < MaxOut);
      erv = (q.size() > 0) && (q[0].due == cyc);
      chk("gnt", 32'(data_gnt_o), 32'(eg));
      chk("inflight", 32'(inflight_o), 32'(q.size()));
      chk("rvalid", 32'(data_rvalid_o), 32'(erv));
      if (erv) begin
         chk("err", 32'(data_err_o), 32'(q[0].err));
         if (q[0].mask != 4'h0)
            chk("rdata", data_rdata_o & lanes(q[0].mask), q[0].rdata & lanes(q[0].mask));
         void'(q.pop_front());
      end else begin
         chk("idle rdata", data_rdata_o, 32'h0);
         chk("idle err", 32'(data_err_o), 32'h0);
      end
      s_gnt = data_gnt_o; s_rv = data_rvalid_o; s_err = data_err_o; s_rdata = data_rdata_o;
      if (eg) begin
         e.due = cyc + Lat; e.err = !hit; e.rdata = 32'h0; e.mask = 4'hF;
         if (hit && !we) begin
            e.rdata = mem[idx]; e.mask = kn[idx];
         end
         if (hit && we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) begin
                  mem[idx][8*b +: 8] = wdata[8*b +: 8];
                  kn[idx][b] = 1'b1;
               end
            end
         end
         q.push_back(e);
      end
      @(posedge clk_i); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic do_txn(input bit we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output bit er);
      int n = 0;
      rd = 32'h0; er = 1'b0;
      do begin
         step(1'b1, we, be, addr, wdata, 1'b0); n++;
      end while (!s_gnt && n < 20);
      if (!s_gnt) begin
         checks++; errors++;
         $display("FAIL txn grant timeout addr %h", addr);
         return;
      end
      n = 0; s_rv = 1'b0;
      while (!s_rv && n < 10) begin
         idle(1); n++;
      end
      if (!s_rv) begin
         checks++; errors++;
         $display("FAIL txn response timeout addr %h", addr);
      end else begin
         rd = s_rdata; er = s_err;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[14];
      logic [31:0] rd, last, baddr[6];
      bit          er, hold, rreq, rwe;
      logic [3:0]  rb;
      logic [31:0] ra, rw;
      bit          pat[8];
      int          grants, rvs;

      for (int i = 0; i < Words; i++) begin
         mem[i] = 32'h0; kn[i] = 4'h0;
      end
      tbl[0]  = '{1'b1, 4'hF, 32'h0001_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tbl[1]  = '{1'b0, 4'hF, 32'h0001_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      tbl[2]  = '{1'b1, 4'hF, 32'h0001_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
      tbl[3]  = '{1'b1, 4'h5, 32'h0001_0020, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
      tbl[4]  = '{1'b0, 4'hF, 32'h0001_0020, 32'h0000_0000, 32'h11BB_33DD, 1'b0};
      tbl[5]  = '{1'b1, 4'hF, 32'h0001_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
      tbl[6]  = '{1'b0, 4'hF, 32'h0000_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tbl[7]  = '{1'b0, 4'hF, 32'h0001_0400, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tbl[8]  = '{1'b1, 4'hF, 32'h0001_0400, 32'h1234_5678, 32'h0000_0000, 1'b1};
      tbl[9]  = '{1'b0, 4'hF, 32'h0001_0000, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};
      tbl[10] = '{1'b1, 4'h0, 32'h0001_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      tbl[11] = '{1'b0, 4'h0, 32'h0001_0013, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      tbl[12] = '{1'b1, 4'hF, 32'h0001_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      tbl[13] = '{1'b0, 4'hF, 32'h0001_03FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};

      // Reset state.
      @(negedge clk_i);
      chk("reset rvalid", 32'(data_rvalid_o), 32'h0);
      chk("reset rdata", data_rdata_o, 32'h0);
      chk("reset err", 32'(data_err_o), 32'h0);
      chk("reset inflight", 32'(inflight_o), 32'h0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      cyc = 0;

      // Directed table.
      for (int i = 0; i < 14; i++) begin
         do_txn(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, rd, er);
         chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rdata);
         chk($sformatf("tbl%0d err", i), 32'(er), 32'(tbl[i].exp_err));
      end

      // Load issued the cycle after a store to the same word sees new data.
      step(1'b1, 1'b1, 4'hF, 32'h0001_0030, 32'h5A5A_A5A5, 1'b0);
      step(1'b1, 1'b0, 4'hF, 32'h0001_0030, 32'h0000_0000, 1'b0);
      last = 32'h0;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         if (s_rv) last = s_rdata;
      end
      chk("ld after st", last, 32'h5A5A_A5A5);

      // Back-to-back loads under the outstanding limit.
      baddr[0] = 32'h0001_0000; baddr[1] = 32'h0001_0010; baddr[2] = 32'h0001_0020;
      baddr[3] = 32'h0001_03FC; baddr[4] = 32'h0001_0030; baddr[5] = 32'h0001_0010;
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      grants = 0;
      for (int c = 0; c < 8; c++) begin
         step(1'b1, 1'b0, 4'hF, baddr[grants], 32'h0, 1'b0);
         chk($sformatf("b2b gnt c%0d", c), 32'(s_gnt), 32'(pat[c]));
         if (s_gnt) grants++;
         if (grants == 6) break;
      end
      chk("b2b grants", 32'(grants), 32'd6);
      idle(4);

      // Stall holds off the grant.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 4'hF, 32'h0001_0020, 32'h0, 1'b1);
         chk("stall gnt", 32'(s_gnt), 32'h0);
      end
      step(1'b1, 1'b0, 4'hF, 32'h0001_0020, 32'h0, 1'b0);
      chk("post-stall gnt", 32'(s_gnt), 32'h1);
      rvs = 0;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         if (s_rv) rvs++;
      end
      chk("post-stall rvalids", 32'(rvs), 32'd1);

      // Reset with two loads pending.
      step(1'b1, 1'b0, 4'hF, 32'h0001_0010, 32'h0, 1'b0);
      step(1'b1, 1'b0, 4'hF, 32'h0001_0020, 32'h0, 1'b0);
      data_req_i = 1'b0;
      rst_ni = 1'b0;
      @(negedge clk_i);
      chk("mid-reset rvalid", 32'(data_rvalid_o), 32'h0);
      chk("mid-reset inflight", 32'(inflight_o), 32'h0);
      q.delete();
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      cyc++;
      rvs = 0;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         if (s_rv) rvs++;
      end
      chk("post-reset rvalids", 32'(rvs), 32'd0);
      do_txn(1'b0, 4'hF, 32'h0001_0010, 32'h0, rd, er);
      chk("retained data", rd, 32'hDEAD_BEEF);

      // Randomized traffic against the model.
      hold = 1'b0; rreq = 1'b0; rwe = 1'b0; rb = 4'h0; ra = Base; rw = 32'h0;
      for (int i = 0; i < 400; i++) begin
         if (!hold) begin
            rreq = ($urandom_range(0, 3) != 0);
            rwe  = 1'($urandom_range(0, 1));
            rb   = 4'($urandom);
            rw   = $urandom;
            if ($urandom_range(0, 9) == 0)
               ra = ($urandom_range(0, 1) == 0) ? Base - 32'($urandom_range(1, 64))
                                                : Base + 32'h400 + 32'($urandom_range(0, 64));
            else
               ra = Base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         end
         step(rreq, rwe, rb, ra, rw, $urandom_range(0, 4) == 0);
         hold = rreq && !s_gnt;
      end
      for (int i = 0; i < 10 && hold; i++) begin
         step(1'b1, rwe, rb, ra, rw, 1'b0);
         hold = !s_gnt;
      end
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
